// File: rtl/sha256_miner_ctrl.sv
// Nonce-search controller: drives an external sha256_core through a double SHA-256 of an 80-byte header.
// Optional per-CHECK hash counter output (hash_count) is built when SHA256_MINER_STATS_EN is defined.
module sha256_miner_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [607:0] header_76,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  nonce_out,
  output logic [255:0] hash_out,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [255:0] core_digest
`ifdef SHA256_MINER_STATS_EN
  ,
  output logic [31:0]  hash_count
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // ISS0  | init strobe, block = header bytes 0..63
  // WT0   | waiting for first half of hash 1
  // ISS1  | next strobe, block = header tail + nonce + padding
  // WT1   | waiting for hash 1
  // ISS2  | init strobe, block = hash 1 + padding
  // WT2   | waiting for hash 2
  // CHECK | compare byte-reversed hash 2 with target
  // DONE  | done pulse, results published
  typedef enum logic [3:0] {
    S_IDLE, S_ISS0, S_WT0, S_ISS1, S_WT1, S_ISS2, S_WT2, S_CHECK, S_DONE
  } state_t;

  state_t         state;
  logic [607:0]   hdr_q;
  logic [31:0]    nonce_end_q;
  logic [255:0]   target_q;
  logic [31:0]    cur_nonce;
  logic [255:0]   final_digest;
  logic           abort_q;
  logic           wait_cnt;
  logic [255:0]   hash_le;
  logic           match;
  logic           abort_now;
  logic           in_wt;
  logic           wt_exit;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
    return r;
  endfunction

  assign core_mode = 1'b1;
  assign hash_le   = bswap256(final_digest);
  assign match     = (hash_le <= target_q);
  assign abort_now = abort_q | stop;
  assign in_wt     = (state == S_WT0) || (state == S_WT1) || (state == S_WT2);
  // the core may still show a stale ready in the cycle right after a strobe
  assign wt_exit   = in_wt && !wait_cnt && core_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      hdr_q        <= '0;
      nonce_end_q  <= '0;
      target_q     <= '0;
      cur_nonce    <= '0;
      final_digest <= '0;
      abort_q      <= 1'b0;
      wait_cnt     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      nonce_out    <= '0;
      hash_out     <= '0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_block   <= '0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      if (state != S_IDLE && stop) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            hdr_q       <= header_76;
            nonce_end_q <= nonce_end;
            target_q    <= target;
            cur_nonce   <= nonce_start;
            found       <= 1'b0;
            busy        <= 1'b1;
            abort_q     <= 1'b0;
            core_block  <= header_76[607:96];
            core_init   <= 1'b1;
            wait_cnt    <= 1'b1;
            state       <= S_ISS0;
          end
        end
        S_ISS0: state <= S_WT0;
        S_ISS1: state <= S_WT1;
        S_ISS2: state <= S_WT2;
        S_WT0, S_WT1, S_WT2: begin
          wait_cnt <= 1'b0;
          if (wt_exit) begin
            wait_cnt <= 1'b1;
            if (state == S_WT2) final_digest <= core_digest;
            if (abort_now) begin
              state     <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              found     <= 1'b0;
              nonce_out <= cur_nonce;
              hash_out  <= hash_le;
            end else if (state == S_WT0) begin
              // zero fill sized so the padded 80-byte message block is exactly 512 bits
              core_block <= {hdr_q[95:0], bswap32(cur_nonce), 32'h8000_0000, 288'h0, 64'd640};
              core_next  <= 1'b1;
              state      <= S_ISS1;
            end else if (state == S_WT1) begin
              core_block <= {core_digest, 32'h8000_0000, 160'h0, 64'd256};
              core_init  <= 1'b1;
              state      <= S_ISS2;
            end else begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (abort_now || match || cur_nonce == nonce_end_q) begin
            state     <= S_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            found     <= match && !abort_now;
            nonce_out <= cur_nonce;
            hash_out  <= hash_le;
          end else begin
            cur_nonce  <= cur_nonce + 32'd1;
            core_block <= hdr_q[607:96];
            core_init  <= 1'b1;
            wait_cnt   <= 1'b1;
            state      <= S_ISS0;
          end
        end
        S_DONE: begin
          abort_q <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHA256_MINER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_count <= '0;
    end else if (state == S_IDLE && start) begin
      hash_count <= '0;
    end else if (state == S_CHECK && hash_count != 32'hFFFF_FFFF) begin
      hash_count <= hash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_miner_ctrl.sv
// Bench for sha256_miner_ctrl: behavioural SHA-256 core, expected-result queue and a done/strobe monitor.
module tb_sha256_miner_ctrl;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic [607:0] header_76;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [255:0] target;
  logic         busy;
  logic         done;
  logic         found;
  logic [31:0]  nonce_out;
  logic [255:0] hash_out;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic [511:0] core_block;
  logic         core_ready;
  logic [255:0] core_digest;
`ifdef SHA256_MINER_STATS_EN
  logic [31:0]  hash_count;
`endif

  sha256_miner_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .header_76(header_76), .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .busy(busy), .done(done), .found(found), .nonce_out(nonce_out), .hash_out(hash_out),
    .core_init(core_init), .core_next(core_next), .core_mode(core_mode), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest)
`ifdef SHA256_MINER_STATS_EN
    , .hash_count(hash_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [607:0] GEN_HDR = {32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a, 32'h29ab5f49, 32'hffff001d};
  localparam logic [255:0] GEN_TGT  = {48'h00000000FFFF, 208'h0};
  localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [31:0]  GEN_NONCE = 32'h7c2bac1d;

  localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int t = 0; t < 64; t++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Bitcoin block hash of an 80-byte header, reported in display (byte-reversed) order
  function automatic logic [255:0] ref_hash_le(input logic [607:0] hdr, input logic [31:0] nonce);
    logic [255:0] d1, d2, r;
    logic [31:0]  nle;
    nle = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
    d1 = sha_compress(SHA_IV, hdr[607:96]);
    d1 = sha_compress(d1, {hdr[95:0], nle, 32'h80000000, 288'h0, 64'd640});
    d2 = sha_compress(SHA_IV, {d1, 32'h80000000, 160'h0, 64'd256});
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = d2[255-8*i -: 8];
    return r;
  endfunction

  // behavioural core: ready drops for lat_cfg cycles per strobe; core_lag delays the drop by one cycle
  int           lat_cfg;
  logic         core_lag;
  int           core_cnt;
  logic         core_drop;
  logic [255:0] core_pend;

  always @(posedge clk) begin
    if (reset) begin
      core_ready  <= 1'b1;
      core_digest <= '0;
      core_cnt    <= 0;
      core_drop   <= 1'b0;
      core_pend   <= '0;
    end else if (core_init || core_next) begin
      core_ready <= core_lag;
      core_drop  <= core_lag;
      core_cnt   <= lat_cfg;
      core_pend  <= sha_compress(core_init ? SHA_IV : core_digest, core_block);
    end else begin
      if (core_drop) begin
        core_ready <= 1'b0;
        core_drop  <= 1'b0;
      end
      if (core_cnt == 1) begin
        core_ready  <= 1'b1;
        core_digest <= core_pend;
      end
      if (core_cnt != 0) core_cnt <= core_cnt - 1;
    end
  end

  typedef struct packed {
    logic         found;
    logic [31:0]  nonce;
    logic         chk_hash;
    logic [255:0] hash;
    logic [31:0]  count;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic quiet = 1'b1;
  logic prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // no strobes are allowed between a done/reset and the next start
  always @(posedge clk) begin
    if (reset || done) quiet <= 1'b1;
    else if (start)    quiet <= 1'b0;
  end

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done (nonce_out=%0h)", nonce_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("found", 256'(found), 256'(mon_e.found));
        chk("nonce_out", 256'(nonce_out), 256'(mon_e.nonce));
        chk("busy_at_done", 256'(busy), 256'd0);
        if (mon_e.chk_hash) chk("hash_out", hash_out, mon_e.hash);
`ifdef SHA256_MINER_STATS_EN
        chk("hash_count", 256'(hash_count), 256'(mon_e.count));
`endif
      end
    end
    if (core_init || core_next) begin
      chk("strobe_overlap", 256'(core_init & core_next), 256'd0);
      chk("strobe_ready", 256'(core_ready), 256'd1);
      chk("strobe_width", 256'(prev_strobe), 256'd0);
      chk("strobe_while_quiet", 256'(quiet), 256'd0);
    end
    prev_strobe <= core_init | core_next;
  end

  task automatic push_exp(input logic f, input logic [31:0] n, input logic ch,
                          input logic [255:0] h, input logic [31:0] cnt);
    exp_t e;
    e.found = f; e.nonce = n; e.chk_hash = ch; e.hash = h; e.count = cnt;
    sb_q.push_back(e);
  endtask

  task automatic start_run(input logic [607:0] h, input logic [31:0] ns, input logic [31:0] ne,
                           input logic [255:0] tg, input logic with_stop);
    header_76 = h; nonce_start = ns; nonce_end = ne; target = tg;
    start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    header_76 = ~h; nonce_start = ns + 32'h100; nonce_end = ns + 32'h100; target = '1;
    chk("busy_after_start", 256'(busy), 256'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles want done", budget);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_found", 256'(found), 256'd0);
    chk("rst_nonce_out", 256'(nonce_out), 256'd0);
    chk("rst_hash_out", hash_out, 256'd0);
    chk("rst_core_init", 256'(core_init), 256'd0);
    chk("rst_core_next", 256'(core_next), 256'd0);
    chk("rst_core_block", core_block[511:256] | core_block[255:0], 256'd0);
    chk("rst_core_mode", 256'(core_mode), 256'd1);
`ifdef SHA256_MINER_STATS_EN
    chk("rst_hash_count", 256'(hash_count), 256'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    header_76 = '0; nonce_start = '0; nonce_end = '0; target = '0;
    lat_cfg = 10; core_lag = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    // genesis block, single nonce
    push_exp(1'b1, GEN_NONCE, 1'b1, GEN_HASH, 32'd1);
    start_run(GEN_HDR, GEN_NONCE, GEN_NONCE, GEN_TGT, 1'b0);
    wait_done(500);

    // nonce range ending past the hit, lagging ready, plus a start while busy
    lat_cfg = 5; core_lag = 1'b1;
    push_exp(1'b1, GEN_NONCE, 1'b1, GEN_HASH, 32'd4);
    start_run(GEN_HDR, 32'h7c2bac1a, 32'h7c2bac1f, GEN_TGT, 1'b0);
    repeat (6) @(negedge clk);
    header_76 = '0; nonce_start = '0; nonce_end = '0; target = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1000);

    // wrap through 0xFFFFFFFF with an unreachable target
    lat_cfg = 3; core_lag = 1'b0;
    push_exp(1'b0, 32'h1, 1'b1, ref_hash_le(GEN_HDR, 32'h1), 32'd3);
    start_run(GEN_HDR, 32'hFFFF_FFFF, 32'h0000_0001, 256'd0, 1'b0);
    wait_done(1000);

    // target boundary: equal matches, one below does not
    push_exp(1'b1, GEN_NONCE, 1'b1, GEN_HASH, 32'd1);
    start_run(GEN_HDR, GEN_NONCE, GEN_NONCE, GEN_HASH, 1'b0);
    wait_done(500);
    push_exp(1'b0, GEN_NONCE, 1'b1, GEN_HASH, 32'd1);
    start_run(GEN_HDR, GEN_NONCE, GEN_NONCE, GEN_HASH - 256'd1, 1'b0);
    wait_done(500);

    // stop while idle is ignored; start+stop together is a plain start
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    push_exp(1'b1, GEN_NONCE, 1'b1, GEN_HASH, 32'd1);
    start_run(GEN_HDR, GEN_NONCE, GEN_NONCE, GEN_TGT, 1'b1);
    wait_done(500);

    // abort 20 cycles into a full-range search
    lat_cfg = 12;
    push_exp(1'b0, 32'h0, 1'b0, 256'd0, 32'd0);
    start_run(GEN_HDR, 32'h0, 32'hFFFF_FFFF, 256'd0, 1'b0);
    repeat (19) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(200);
    repeat (40) @(negedge clk);

    // reset while waiting on the first hash
    start_run(GEN_HDR, GEN_NONCE, GEN_NONCE, GEN_TGT, 1'b0);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (60) @(negedge clk);

    // recovery after reset
    lat_cfg = 3;
    push_exp(1'b1, GEN_NONCE, 1'b1, GEN_HASH, 32'd1);
    start_run(GEN_HDR, GEN_NONCE, GEN_NONCE, GEN_TGT, 1'b0);
    wait_done(500);
    repeat (5) @(negedge clk);

    chk("pending_results", 256'(sb_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
